// File: rtl/fft_frame_loader_pkg.sv
// Shared complex sample type and loader constants for the FFT input-side frame assembler.
// The optional FFT_LOADER_Q16_EN build uses Q16_MAX/Q16_MIN and the integer limits for saturation.
package fft_frame_loader_pkg;

  localparam int CPLX_W = 32;

  typedef struct packed {
    logic signed [CPLX_W-1:0] r;
    logic signed [CPLX_W-1:0] i;
  } complex_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    WAIT = 1'b1
  } loader_state_e;

  localparam logic [CPLX_W-1:0] Q16_MAX     = 32'h7FFF_0000;
  localparam logic [CPLX_W-1:0] Q16_MIN     = 32'h8000_0000;
  localparam int                Q16_INT_MAX = 32767;
  localparam int                Q16_INT_MIN = -32768;

  function automatic complex_t complex_make(input logic [CPLX_W-1:0] re,
                                            input logic [CPLX_W-1:0] im);
    complex_t c;
    c.r = re;
    c.i = im;
    return c;
  endfunction

endpackage

// File: rtl/fft_q16_sat.sv
// Combinational integer -> Q16.16 converter with saturation at the Q16.16 integer range.
// Only instantiated when FFT_LOADER_Q16_EN is defined.
module fft_q16_sat
  import fft_frame_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] int_in,
  output logic signed [DATA_WIDTH-1:0] q16_out
);

  localparam logic signed [DATA_WIDTH-1:0] LIM_HI = DATA_WIDTH'(Q16_INT_MAX);
  localparam logic signed [DATA_WIDTH-1:0] LIM_LO = DATA_WIDTH'(Q16_INT_MIN);

  // Clamp out-of-range integers, otherwise scale by 2^16
  always_comb begin
    q16_out = '0;
    if (int_in > LIM_HI) begin
      q16_out = DATA_WIDTH'(Q16_MAX);
    end else if (int_in < LIM_LO) begin
      q16_out = DATA_WIDTH'(Q16_MIN);
    end else begin
      q16_out = int_in <<< 5'd16;
    end
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Collects N complex samples from a valid/ready stream into a parallel frame with a frame handshake.
// Define FFT_LOADER_Q16_EN to treat incoming components as integers converted to Q16.16.
module fft_frame_loader
  import fft_frame_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8,
  parameter int IDX_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  complex_t    s_data,
  input  logic        s_last,
  output complex_t    frame_out [0:N-1],
  output logic        frame_valid,
  input  logic        dst_ready,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  loader_state_e         state_r;
  loader_state_e         state_nxt_s;
  logic [IDX_W-1:0]      cnt_r;
  complex_t              sample_buf_r [0:N-1];
  complex_t              wr_data_s;
  logic [DATA_WIDTH-1:0] wr_r_s;
  logic [DATA_WIDTH-1:0] wr_i_s;
  logic                  accept_s;
  logic                  xfer_s;
  logic                  last_slot_s;
  logic                  full_accept_s;
  logic                  early_last_s;
  logic                  direct_load_s;
  logic                  park_s;
  logic                  release_s;

`ifdef FFT_LOADER_Q16_EN
  fft_q16_sat #(.DATA_WIDTH(DATA_WIDTH)) u_sat_r (.int_in(s_data.r), .q16_out(wr_r_s));
  fft_q16_sat #(.DATA_WIDTH(DATA_WIDTH)) u_sat_i (.int_in(s_data.i), .q16_out(wr_i_s));
`else
  assign wr_r_s = s_data.r;
  assign wr_i_s = s_data.i;
`endif

  assign wr_data_s = complex_make(wr_r_s, wr_i_s);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: park a full buffer while the output is still held, release it on transfer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (park_s) state_nxt_s = WAIT;
        else        state_nxt_s = FILL;
      end
      WAIT: begin
        if (xfer_s) state_nxt_s = FILL;
        else        state_nxt_s = WAIT;
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // Handshake and datapath control derived from registered state only
  always_comb begin
    s_ready       = (state_r == FILL);
    accept_s      = s_valid && (state_r == FILL);
    xfer_s        = frame_valid && dst_ready;
    last_slot_s   = (cnt_r == LAST_IDX);
    full_accept_s = accept_s && last_slot_s;
    early_last_s  = accept_s && s_last && !last_slot_s;
    direct_load_s = full_accept_s && (!frame_valid || dst_ready);
    park_s        = full_accept_s && frame_valid && !dst_ready;
    release_s     = (state_r == WAIT) && xfer_s;
  end

  // Sample buffer, output frame register, counters and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 16'd0;
      for (int k = 0; k < N; k++) begin
        sample_buf_r[k] <= '0;
        frame_out[k]    <= '0;
      end
    end else begin
      frame_err <= early_last_s || (full_accept_s && !s_last);

      if (accept_s) begin
        sample_buf_r[cnt_r] <= wr_data_s;
      end

      if (early_last_s || full_accept_s) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + IDX_W'(1);
      end

      if (xfer_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      // The last sample bypasses the buffer so the frame appears one cycle after it
      if (direct_load_s) begin
        for (int k = 0; k < N - 1; k++) begin
          frame_out[k] <= sample_buf_r[k];
        end
        frame_out[N-1] <= wr_data_s;
      end else if (release_s) begin
        for (int k = 0; k < N; k++) begin
          frame_out[k] <= sample_buf_r[k];
        end
      end

      if (direct_load_s || release_s) begin
        frame_valid <= 1'b1;
      end else if (xfer_s) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
